// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and decoder-side
// handshakes of the UART RX byte FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 8,
  parameter int CWIDTH = $clog2(DEPTH) + 1
);
  logic [DWIDTH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CWIDTH-1:0] count;
  logic              overflow;
  logic              clr_overflow;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  count,
    input  overflow,
    output clr_overflow
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output count,
    output overflow,
    input  clr_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO from UART receiver to MMIO
// decoder, with sticky overflow on dropped bytes.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 8,
  parameter int CWIDTH = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CWIDTH-1:0] cnt;
  logic [CWIDTH-1:0] cnt_nxt;
  logic              ovf;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;

  assign full  = (cnt == CWIDTH'(DEPTH));
  assign empty = (cnt == '0);
  assign push  = bus.in_valid && !full;
  assign drop  = bus.in_valid && full;
  assign pop   = bus.out_ready && !empty;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;

  // Storage write; contents are not reset, only pointers.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Next occupancy from push/pop combination.
  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      (push && !pop): cnt_nxt = cnt + CWIDTH'(1);
      (pop && !push): cnt_nxt = cnt - CWIDTH'(1);
      default:        cnt_nxt = cnt;
    endcase
  end

  // Pointers, count and sticky overflow; a drop beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt_nxt;
      if (drop) begin
        ovf <= 1'b1;
      end else if (bus.clr_overflow) begin
        ovf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, directed corner
// sequences and random traffic vs a queue model.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 8;
  localparam int DWIDTH = 8;
  localparam int CWIDTH = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;

  uart_rx_fifo_if #(
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH),
    .CWIDTH(CWIDTH)
  ) bus ();

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH),
    .CWIDTH(CWIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       clr;
    int         e_cnt;
    logic       e_val;
    logic [7:0] e_data;
    logic       e_ovf;
  } vec_t;

  vec_t tbl [14];

  logic [7:0] mq [$];
  logic       movf;
  int         n_chk;
  int         n_fail;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic iv,
                      input logic [7:0] d,
                      input logic ordy,
                      input logic clr);
    bit full;
    bit pop;
    bit drop;
    logic [7:0] hd;
    rst_n            = r;
    bus.in_valid     = iv;
    bus.in_data      = d;
    bus.out_ready    = ordy;
    bus.clr_overflow = clr;
    full = (mq.size() == DEPTH);
    pop  = ordy && (mq.size() != 0);
    drop = iv && full;
    if (!r) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (iv && !full) mq.push_back(d);
      if (drop) movf = 1'b1;
      else if (clr) movf = 1'b0;
    end
    @(posedge clk);
    #1;
    hd = (mq.size() != 0) ? mq[0] : 8'h00;
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("out_valid", 32'(bus.out_valid),
        32'(mq.size() != 0));
    chk("out_data", 32'(bus.out_data), 32'(hd));
    chk("in_ready", 32'(bus.in_ready),
        32'(mq.size() != DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(movf));
    chk("count_bound", 32'(bus.count <= DEPTH), 1);
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic popc();
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    movf   = 1'b0;
    rst_n  = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.out_ready    = 1'b0;
    bus.clr_overflow = 1'b0;

    tbl[0]  = '{0, 1, 8'hAA, 0, 0, 0, 0, 8'h00, 0};
    tbl[1]  = '{0, 1, 8'hAA, 0, 0, 0, 0, 8'h00, 0};
    tbl[2]  = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0};
    tbl[3]  = '{1, 1, 8'h41, 0, 0, 1, 1, 8'h41, 0};
    tbl[4]  = '{1, 0, 8'h00, 0, 0, 1, 1, 8'h41, 0};
    tbl[5]  = '{1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
    tbl[6]  = '{1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
    tbl[7]  = '{1, 1, 8'h10, 0, 0, 1, 1, 8'h10, 0};
    tbl[8]  = '{1, 1, 8'h20, 0, 0, 2, 1, 8'h10, 0};
    tbl[9]  = '{1, 1, 8'h30, 1, 0, 2, 1, 8'h20, 0};
    tbl[10] = '{1, 0, 8'h00, 1, 0, 1, 1, 8'h30, 0};
    tbl[11] = '{1, 1, 8'h7E, 1, 0, 1, 1, 8'h7E, 0};
    tbl[12] = '{1, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0};
    tbl[13] = '{0, 1, 8'h99, 0, 0, 0, 0, 8'h00, 0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst_n, tbl[i].iv, tbl[i].d,
           tbl[i].ordy, tbl[i].clr);
      chk($sformatf("tbl%0d_cnt", i),
          32'(bus.count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_val", i),
          32'(bus.out_valid), 32'(tbl[i].e_val));
      chk($sformatf("tbl%0d_data", i),
          32'(bus.out_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_rdy", i),
          32'(bus.in_ready),
          32'(tbl[i].e_cnt != DEPTH));
      chk($sformatf("tbl%0d_ovf", i),
          32'(bus.overflow), 32'(tbl[i].e_ovf));
    end

    do_reset();
    for (int i = 0; i < 8; i++) push(8'(i));
    chk("fill_count", 32'(bus.count), 8);
    chk("fill_in_ready", 32'(bus.in_ready), 0);
    push(8'hFF);
    chk("fill_drop_ovf", 32'(bus.overflow), 1);
    chk("fill_drop_count", 32'(bus.count), 8);
    for (int i = 0; i < 8; i++) begin
      chk("fill_order", 32'(bus.out_data), i);
      popc();
    end
    chk("drain_empty", 32'(bus.out_valid), 0);
    chk("drain_data0", 32'(bus.out_data), 0);

    do_reset();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("sim_count", 32'(bus.count), 3);
    chk("sim_head", 32'(bus.out_data), 32'h02);
    popc();
    popc();
    chk("sim_last", 32'(bus.out_data), 32'h55);
    popc();

    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_sim_count", 32'(bus.count), 7);
    chk("full_sim_ovf", 32'(bus.overflow), 1);
    push(8'h66);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    chk("clr_vs_drop", 32'(bus.overflow), 1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_alone", 32'(bus.overflow), 0);
    for (int i = 0; i < 8; i++) popc();
    chk("no_55_left", 32'(bus.count), 0);

    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    step(1'b0, 1'b1, 8'h12, 1'b1, 1'b0);
    chk("rst5_count", 32'(bus.count), 0);
    chk("rst5_valid", 32'(bus.out_valid), 0);

    do_reset();
    for (int k = 0; k < 20; k++) begin
      int lvl;
      lvl = k % 9;
      for (int j = 0; j < lvl; j++)
        push(8'($urandom));
      if (lvl > 0)
        step(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);
      for (int j = 0; j < lvl; j++) popc();
    end

    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic r;
      logic iv;
      logic ordy;
      logic clr;
      r    = ($urandom_range(0, 99) != 0);
      iv   = ($urandom_range(0, 9) < 6);
      ordy = ($urandom_range(0, 9) < 4);
      clr  = ($urandom_range(0, 15) == 0);
      step(r, iv, 8'($urandom), ordy, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
